// File: rtl/vmem_pkg.sv
// Shared definitions for the video display-control fetch bus: widths,
// responder state encoding and address field extraction helpers.
package vmem_pkg;

  localparam int FETCH_DATA_W     = 16;
  localparam int FETCH_ADDR_MAX_W = 32;

  typedef enum logic [1:0] {
    VMEM_IDLE = 2'd0,
    VMEM_REQ  = 2'd1,
    VMEM_FILL = 2'd2,
    VMEM_RESP = 2'd3
  } vmem_state_e;

  // Word index inside a line: byte address bits [wb:1].
  function automatic logic [FETCH_ADDR_MAX_W-1:0] vmem_word_idx(
    input logic [FETCH_ADDR_MAX_W-1:0] addr,
    input int                          wb
  );
    return (addr >> 1) & ((32'd1 << wb) - 32'd1);
  endfunction

  // Line tag: byte address bits above the line offset.
  function automatic logic [FETCH_ADDR_MAX_W-1:0] vmem_line_tag(
    input logic [FETCH_ADDR_MAX_W-1:0] addr,
    input int                          wb
  );
    return addr >> (wb + 1);
  endfunction

  // Line-aligned byte address: bits [wb:0] cleared.
  function automatic logic [FETCH_ADDR_MAX_W-1:0] vmem_line_base(
    input logic [FETCH_ADDR_MAX_W-1:0] addr,
    input int                          wb
  );
    return addr & ~((32'd1 << (wb + 1)) - 32'd1);
  endfunction

endpackage

// File: rtl/vmem_line_buffer.sv
// One-line read buffer: LINE_WORDS x 16-bit registers, written one burst
// beat at a time, read combinationally by word index.
module vmem_line_buffer
  import vmem_pkg::*;
#(
  parameter  int LINE_WORDS = 4,
  localparam int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [IDX_W-1:0]        waddr,
  input  logic [FETCH_DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]        raddr,
  output logic [FETCH_DATA_W-1:0] rdata
);

  logic [FETCH_DATA_W-1:0] line_q [LINE_WORDS];

  // Capture a burst beat into its slot; contents are qualified by the
  // responder's valid flag, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (we) begin
      line_q[waddr] <= wdata;
    end
  end

  assign rdata = line_q[raddr];

endmodule

// File: rtl/vmem_fetch_responder.sv
// Fetch-bus responder for the display-control sequencer. Serves word reads
// from a one-line buffer and refills it with fixed-length bursts from the
// system RAM arbiter on a miss.
module vmem_fetch_responder
  import vmem_pkg::*;
#(
  parameter int ADDR_W     = 22,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              as,
  output logic [15:0]       dout,
  output logic              bus_ack,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata,
  input  logic              inv_valid,
  input  logic [ADDR_W-1:0] inv_addr
);

  localparam int WB    = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_W - WB - 1;

  localparam logic [1:0] ST_IDLE = 2'(VMEM_IDLE);
  localparam logic [1:0] ST_REQ  = 2'(VMEM_REQ);
  localparam logic [1:0] ST_FILL = 2'(VMEM_FILL);
  localparam logic [1:0] ST_RESP = 2'(VMEM_RESP);

  logic [1:0]       state;
  logic             valid;
  logic [TAG_W-1:0] tag;
  logic [TAG_W-1:0] req_tag;
  logic [WB-1:0]    req_word;
  logic             poison;
  logic [WB-1:0]    beat;

  logic [TAG_W-1:0] cur_tag;
  logic [WB-1:0]    cur_word;
  logic [TAG_W-1:0] inv_tag;
  logic [ADDR_W-1:0] cur_base;
  logic [WB-1:0]    rd_idx;
  logic [15:0]      rd_data;
  logic             pending;
  logic             tag_hit;
  logic             inv_line;
  logic             inv_fill;
  logic             last_beat;

  assign cur_tag  = TAG_W'(vmem_line_tag(32'(address), WB));
  assign cur_word = WB'(vmem_word_idx(32'(address), WB));
  assign cur_base = ADDR_W'(vmem_line_base(32'(address), WB));
  assign inv_tag  = TAG_W'(vmem_line_tag(32'(inv_addr), WB));

  // The master moves to its next address on the ack edge, so the ack cycle
  // itself never counts as a new request.
  assign pending   = as && !bus_ack;
  assign tag_hit   = valid && (cur_tag == tag);
  assign inv_line  = inv_valid && valid && (inv_tag == tag);
  assign inv_fill  = inv_valid && (inv_tag == req_tag);
  assign last_beat = (beat == WB'(LINE_WORDS - 1));

  // In RESP the buffer is read at the latched word; otherwise at the live one.
  assign rd_idx = (state == ST_RESP) ? req_word : cur_word;

  vmem_line_buffer #(
    .LINE_WORDS(LINE_WORDS)
  ) u_line (
    .clk  (clk),
    .we   ((state == ST_FILL) && mem_rvalid),
    .waddr(beat),
    .wdata(mem_rdata),
    .raddr(rd_idx),
    .rdata(rd_data)
  );

  // Responder FSM: hit service, burst request, line fill and post-fill ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      valid    <= 1'b0;
      tag      <= '0;
      req_tag  <= '0;
      req_word <= '0;
      poison   <= 1'b0;
      beat     <= '0;
      bus_ack  <= 1'b0;
      dout     <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      bus_ack <= 1'b0;
      if (inv_line) begin
        valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (pending) begin
            if (tag_hit) begin
              // A same-cycle write to this line wins; the read retries as a miss.
              if (!inv_line) begin
                bus_ack <= 1'b1;
                dout    <= rd_data;
              end
            end else begin
              req_tag  <= cur_tag;
              req_word <= cur_word;
              valid    <= 1'b0;
              mem_addr <= cur_base;
              mem_req  <= 1'b1;
              state    <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (inv_fill) begin
            poison <= 1'b1;
          end
          if (mem_ready) begin
            mem_req <= 1'b0;
            beat    <= '0;
            state   <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (inv_fill) begin
            poison <= 1'b1;
          end
          if (mem_rvalid) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              // A write seen during the burst leaves the line unusable for
              // later reads, but the pending read is still answered from it.
              valid <= !(poison || inv_fill);
              tag   <= req_tag;
              state <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (as && (cur_tag == req_tag) && (cur_word == req_word)) begin
            bus_ack <= 1'b1;
            dout    <= rd_data;
          end
          poison <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/vmem_fetch_responder.md
Name: vmem_fetch_responder

Overview:
Bus responder for the video display-control fetch master. The master issues word reads with a held address strobe and expects a one-cycle acknowledge with data. This block answers those reads. It keeps a one-line read buffer filled by fixed-length bursts from the backend memory port, so the master's sequential instruction fetches hit locally. It sits between the display-control sequencer and the system RAM arbiter.

Parameters:
ADDR_W, 22, byte address width of the fetch bus (bit 0 ignored, word granular)
LINE_WORDS, 4, 16-bit words per buffer line and per backend burst (power of 2, 2..16)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
address  in  ADDR_W  fetch byte address from master
as  in  1  address strobe, level; may stay high across back-to-back reads
dout  out  16  read data; valid only in the cycle bus_ack=1
bus_ack  out  1  one-cycle acknowledge of the current read
mem_req  out  1  burst request to backend; held until mem_ready
mem_addr  out  ADDR_W  line-aligned byte address of the burst
mem_ready  in  1  backend accepted the request
mem_rvalid  in  1  one burst beat valid
mem_rdata  in  16  burst beat data, ascending word order
inv_valid  in  1  external write seen; invalidate if same line
inv_addr  in  ADDR_W  byte address of that write

Behaviour:
- Reset: bus_ack=0, dout=0, mem_req=0, mem_addr=0, line valid=0, tag=0, state IDLE. Reset mid-burst abandons the burst; remaining mem_rvalid beats after reset are ignored.
- Field split: WB=log2(LINE_WORDS). word index = address[WB:1]; tag = address[ADDR_W-1:WB+1].
- Request detection: a read is pending when as=1 and bus_ack was 0 in the previous cycle. The master changes address at the ack edge, so the cycle after an ack is never treated as a request.
- Sustained throughput is therefore at most one ack every 2 cycles.
- as dropping before ack cancels the read with no ack. A backend burst already requested always completes and fills the line.
- FSM states: IDLE, REQ, FILL, RESP.
- IDLE:
  - Pending read with valid=1 and tag match is a hit. Register dout=line[word], bus_ack=1 next cycle, stay IDLE. Hit latency is 1 cycle.
  - Pending read that misses: latch the tag and word, set valid=0, set mem_addr = address with bits [WB:0] cleared, set mem_req=1, go to REQ.
- REQ: hold mem_req and mem_addr stable. When mem_ready=1, drop mem_req next cycle, clear the beat counter, go to FILL.
- FILL:
  - Each mem_rvalid writes line[beat] and increments the counter.
  - On beat LINE_WORDS-1: set valid=1 (unless poisoned, see below), load tag, go to RESP.
- RESP:
  - If as=1 and address still maps to the latched tag and word: ack with line[word], then go to IDLE.
  - Otherwise go to IDLE without ack; IDLE re-evaluates the new address as a fresh request.
- Invalidate:
  - inv_valid with a matching tag clears valid in the same cycle.
  - If it matches the line being filled (REQ/FILL), set a poison flag. At fill end valid stays 0, but the pending word is still acked from the fill data (the read is ordered before the write).
  - Poison clears on leaving RESP.
- Simultaneous hit and inv_valid on the same line in IDLE: the invalidate wins. No ack; the read is treated as a miss next cycle.
- bus_ack is never high for two consecutive cycles. mem_req never rises while a burst is outstanding.

Decomposition:
- Shared package vmem_pkg:
  - fetch-bus width constants
  - state enum typedef
  - line/tag/word field-extraction functions, reused by the display-control fetch side
- One natural sub-module, vmem_line_buffer: LINE_WORDS x 16 register array with a write port (beat index, data) and a combinational read port (word index).

Test Plan:
- Cold miss: as=1, address=0x000400, backend ready after 2 cycles, beats 0xA1B2, 0xC3D4, 0xE5F6, 0x0718 → mem_addr=0x000400; one ack with dout=0xA1B2 one cycle after RESP entry.
- Sequential hits: after the fill, reads of 0x402, 0x404, 0x406 → acks every 2nd cycle with 0xC3D4, 0xE5F6, 0x0718; mem_req stays 0.
- Line cross: read 0x000408 → new burst with mem_addr=0x000408; the old line is no longer used.
- Invalidate during FILL: inv_addr=0x000404 at beat 1 → the pending word is still acked; the next read of 0x402 misses and issues a new burst.
- Strobe drop: as falls while in REQ → burst completes, no ack; a later read of the same line hits in 1 cycle.
- Reset mid-FILL after beat 2 → bus_ack=0, mem_req=0, valid=0; the next read of the same address issues a new burst.
